// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states
// and the select/operation codes driven to the datapath.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/rv_decode.sv
// Combinational opcode decode: classifies the instruction and produces the
// per-instruction selects that the sequencer gates by state.
module rv_decode
    import rv_pkg::*;
(
    input  logic [31:0] ir,
    output logic        legal,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        rd_nz,
    output logic [2:0]  imm_type,
    output logic [3:0]  alu_op,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic [1:0]  wb_pc_sel
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign rd_nz     = (ir[11:7] != 5'd0);
    assign unused_ir = ^{ir[31], ir[29:15]};

    always_comb begin
        legal     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        imm_type  = IMM_I;
        alu_op    = ALU_ADD;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        wb_sel    = WB_ALU;
        wb_pc_sel = PC_PLUS4;
        case (opcode)
            OPC_LOAD: begin
                legal     = 1'b1;
                is_load   = 1'b1;
                imm_type  = IMM_I;
                alu_b_sel = 1'b1;
                wb_sel    = WB_MEM;
            end
            OPC_OP_IMM: begin
                // ir[30] only distinguishes SRAI from SRLI; elsewhere it is immediate bits
                legal     = 1'b1;
                imm_type  = IMM_I;
                alu_b_sel = 1'b1;
                alu_op    = {(funct3 == 3'b101) & ir[30], funct3};
            end
            OPC_JALR: begin
                legal     = 1'b1;
                imm_type  = IMM_I;
                alu_b_sel = 1'b1;
                wb_sel    = WB_PC4;
                wb_pc_sel = PC_ALU;
            end
            OPC_STORE: begin
                legal     = 1'b1;
                is_store  = 1'b1;
                imm_type  = IMM_S;
                alu_b_sel = 1'b1;
            end
            OPC_BRANCH: begin
                legal     = 1'b1;
                is_branch = 1'b1;
                imm_type  = IMM_B;
                alu_op    = ALU_SUB;
            end
            OPC_LUI: begin
                legal     = 1'b1;
                imm_type  = IMM_U;
                alu_b_sel = 1'b1;
                wb_sel    = WB_IMM;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                imm_type  = IMM_U;
                alu_a_sel = 1'b1;
                alu_b_sel = 1'b1;
            end
            OPC_JAL: begin
                legal     = 1'b1;
                imm_type  = IMM_J;
                alu_b_sel = 1'b1;
                wb_sel    = WB_PC4;
                wb_pc_sel = PC_IMM;
            end
            OPC_OP: begin
                legal  = 1'b1;
                alu_op = {ir[30], funct3};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multicycle RV32I control unit: state register and sequencing, with all
// datapath controls decoded combinationally from state and ir.
module rv_mc_ctrl
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [3:0]  alu_op,
    output logic [2:0]  imm_type,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t     cur_state;
    logic       illegal_q;

    logic       dec_legal;
    logic       dec_load;
    logic       dec_store;
    logic       dec_branch;
    logic       dec_rd_nz;
    logic [2:0] dec_imm_type;
    logic [3:0] dec_alu_op;
    logic       dec_alu_a_sel;
    logic       dec_alu_b_sel;
    logic [1:0] dec_wb_sel;
    logic [1:0] dec_wb_pc_sel;

    rv_decode u_decode (
        .ir        (ir),
        .legal     (dec_legal),
        .is_load   (dec_load),
        .is_store  (dec_store),
        .is_branch (dec_branch),
        .rd_nz     (dec_rd_nz),
        .imm_type  (dec_imm_type),
        .alu_op    (dec_alu_op),
        .alu_a_sel (dec_alu_a_sel),
        .alu_b_sel (dec_alu_b_sel),
        .wb_sel    (dec_wb_sel),
        .wb_pc_sel (dec_wb_pc_sel)
    );

    // mem_ready is only consulted in FETCH and MEM, the two states that hold mem_req high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_START;
            illegal_q <= 1'b0;
        end else begin
            case (cur_state)
                ST_START:  cur_state <= ST_FETCH;
                ST_FETCH:  if (mem_ready) cur_state <= ST_DECODE;
                ST_DECODE: begin
                    if (dec_legal) begin
                        cur_state <= ST_EXEC;
                    end else begin
                        cur_state <= ST_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (dec_branch)                  cur_state <= ST_FETCH;
                    else if (dec_load || dec_store)  cur_state <= ST_MEM;
                    else                             cur_state <= ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready) cur_state <= dec_store ? ST_FETCH : ST_WB;
                end
                ST_WB:   cur_state <= ST_FETCH;
                ST_TRAP: cur_state <= ST_TRAP;
                default: cur_state <= ST_START;
            endcase
        end
    end

    // Gating with rst drops every strobe the instant reset asserts, before the flops settle
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        imm_type  = IMM_I;
        if (!rst) begin
            if (cur_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
                imm_type  = dec_imm_type;
                alu_op    = dec_alu_op;
                alu_a_sel = dec_alu_a_sel;
                alu_b_sel = dec_alu_b_sel;
            end
            case (cur_state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                ST_EXEC: begin
                    if (dec_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = dec_store;
                    pc_we    = mem_ready & dec_store;
                end
                ST_WB: begin
                    rf_we  = dec_rd_nz;
                    wb_sel = dec_wb_sel;
                    pc_we  = 1'b1;
                    pc_sel = dec_wb_pc_sel;
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign state   = cur_state;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed self-checking bench for rv_mc_ctrl: walks each instruction class
// through the FSM and compares controls against hand-computed values.
module tb_rv_mc_ctrl;

    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [3:0]  alu_op;
    logic [2:0]  imm_type;
    logic        illegal;
    logic [2:0]  state;

    int check_count = 0;
    int fail_count  = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [2:0]  imm;
        logic [3:0]  aluop;
        logic        a_sel;
        logic        b_sel;
        logic [1:0]  wb;
        logic [1:0]  pcsel;
        logic        rf;
    } vec_t;

    // Instructions that run FETCH, DECODE, EXEC, WB, with their expected selects
    vec_t vecs [11] = '{
        '{32'h00500093, 3'd0, 4'h0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1},
        '{32'h00500013, 3'd0, 4'h0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0},
        '{32'hC0000093, 3'd0, 4'h0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1},
        '{32'h4010D093, 3'd0, 4'hD, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1},
        '{32'h0010D093, 3'd0, 4'h5, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1},
        '{32'h402081B3, 3'd0, 4'h8, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1},
        '{32'h0020F1B3, 3'd0, 4'h7, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1},
        '{32'h123450B7, 3'd3, 4'h0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1},
        '{32'h00001097, 3'd3, 4'h0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1},
        '{32'h008000EF, 3'd4, 4'h0, 1'b0, 1'b1, 2'd2, 2'd1, 1'b1},
        '{32'h000080E7, 3'd0, 4'h0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1}
    };

    rv_mc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .mem_ready (mem_ready),
        .br_taken  (br_taken),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .imm_type  (imm_type),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ir_v, input logic ready_v, input logic br_v);
        ir        = ir_v;
        mem_ready = ready_v;
        br_taken  = br_v;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [5:0] strobes();
        return {mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we};
    endfunction

    // Common entry: sitting in FETCH, instruction fetched this cycle, then into EXEC
    task automatic fetchToExec(input logic [31:0] ir_v, input logic br_v);
        applyStimulus(ir_v, 1'b1, br_v);
        checkOutput("fetch state", {29'd0, state}, {29'd0, S_FETCH});
        checkOutput("fetch strobes", {26'd0, strobes()}, 32'b100100);
        tick();
        checkOutput("decode state", {29'd0, state}, {29'd0, S_DECODE});
        checkOutput("decode strobes", {26'd0, strobes()}, 32'd0);
        tick();
        checkOutput("exec state", {29'd0, state}, {29'd0, S_EXEC});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(32'h00500093, 1'b1, 1'b0);
        tick();
        checkOutput("reset state", {29'd0, state}, {29'd0, S_START});
        checkOutput("reset strobes", {26'd0, strobes()}, 32'd0);
        checkOutput("reset illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;
        checkOutput("start strobes", {26'd0, strobes()}, 32'd0);
        tick();

        foreach (vecs[i]) begin
            fetchToExec(vecs[i].ir, 1'b0);
            checkOutput("exec imm_type", {29'd0, imm_type}, {29'd0, vecs[i].imm});
            checkOutput("exec alu_op", {28'd0, alu_op}, {28'd0, vecs[i].aluop});
            checkOutput("exec alu_a_sel", {31'd0, alu_a_sel}, {31'd0, vecs[i].a_sel});
            checkOutput("exec alu_b_sel", {31'd0, alu_b_sel}, {31'd0, vecs[i].b_sel});
            checkOutput("exec strobes", {26'd0, strobes()}, 32'd0);
            tick();
            checkOutput("wb state", {29'd0, state}, {29'd0, S_WB});
            checkOutput("wb rf_we", {31'd0, rf_we}, {31'd0, vecs[i].rf});
            checkOutput("wb wb_sel", {30'd0, wb_sel}, {30'd0, vecs[i].wb});
            checkOutput("wb pc_we", {31'd0, pc_we}, 32'd1);
            checkOutput("wb pc_sel", {30'd0, pc_sel}, {30'd0, vecs[i].pcsel});
            checkOutput("wb mem_req", {31'd0, mem_req}, 32'd0);
            tick();
        end

        // Load with three wait cycles in MEM
        fetchToExec(32'h0040A103, 1'b0);
        checkOutput("lw imm_type", {29'd0, imm_type}, 32'd0);
        checkOutput("lw alu_b_sel", {31'd0, alu_b_sel}, 32'd1);
        mem_ready = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_ready = 1'b1;
            checkOutput("lw mem state", {29'd0, state}, {29'd0, S_MEM});
            checkOutput("lw mem strobes", {26'd0, strobes()}, 32'b101000);
            tick();
        end
        checkOutput("lw wb state", {29'd0, state}, {29'd0, S_WB});
        checkOutput("lw wb_sel", {30'd0, wb_sel}, 32'd1);
        checkOutput("lw rf_we", {31'd0, rf_we}, 32'd1);
        tick();

        // Zero-wait store completes in MEM and updates PC
        fetchToExec(32'h0020A223, 1'b0);
        checkOutput("sw imm_type", {29'd0, imm_type}, 32'd1);
        checkOutput("sw alu_b_sel", {31'd0, alu_b_sel}, 32'd1);
        tick();
        checkOutput("sw mem state", {29'd0, state}, {29'd0, S_MEM});
        checkOutput("sw mem strobes", {26'd0, strobes()}, 32'b111010);
        checkOutput("sw pc_sel", {30'd0, pc_sel}, 32'd0);
        tick();
        checkOutput("sw back to fetch", {29'd0, state}, {29'd0, S_FETCH});

        // Branches: taken then not taken, three cycles from fetch back to fetch
        for (int t = 1; t >= 0; t--) begin
            fetchToExec(32'h00000463, t[0]);
            checkOutput("beq imm_type", {29'd0, imm_type}, 32'd2);
            checkOutput("beq alu_op", {28'd0, alu_op}, 32'h8);
            checkOutput("beq alu_b_sel", {31'd0, alu_b_sel}, 32'd0);
            checkOutput("beq strobes", {26'd0, strobes()}, 32'b000010);
            checkOutput("beq pc_sel", {30'd0, pc_sel}, (t == 1) ? 32'd1 : 32'd0);
            tick();
            checkOutput("beq back to fetch", {29'd0, state}, {29'd0, S_FETCH});
            checkOutput("beq rf_we", {31'd0, rf_we}, 32'd0);
        end

        // Reset asserted mid-cycle while a store waits in MEM
        fetchToExec(32'h0020A223, 1'b0);
        mem_ready = 1'b0;
        tick();
        checkOutput("sw wait strobes", {26'd0, strobes()}, 32'b111000);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst strobes", {26'd0, strobes()}, 32'd0);
        checkOutput("async rst state", {29'd0, state}, {29'd0, S_START});
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        checkOutput("post rst start", {29'd0, state}, {29'd0, S_START});
        tick();
        checkOutput("post rst fetch", {29'd0, state}, {29'd0, S_FETCH});

        // Illegal opcode traps and holds until reset
        applyStimulus(32'h00000000, 1'b1, 1'b0);
        tick();
        checkOutput("trap decode", {29'd0, state}, {29'd0, S_DECODE});
        tick();
        checkOutput("trap state", {29'd0, state}, {29'd0, S_TRAP});
        checkOutput("trap illegal", {31'd0, illegal}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            checkOutput("trap strobes", {26'd0, strobes()}, 32'd0);
            tick();
        end
        checkOutput("trap held", {29'd0, state}, {29'd0, S_TRAP});
        checkOutput("trap illegal held", {31'd0, illegal}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("trap rst illegal", {31'd0, illegal}, 32'd0);
        tick();
        rst = 1'b0;
        checkOutput("trap rst start", {29'd0, state}, {29'd0, S_START});
        tick();
        checkOutput("trap rst fetch", {29'd0, state}, {29'd0, S_FETCH});
        checkOutput("trap rst illegal clear", {31'd0, illegal}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
